// File: rtl/regfile_dump_sequencer.sv
// Walks the core debug select port over a register range and streams each
// captured {index, data} pair to a consumer over a valid/ready handshake.
module regfile_dump_sequencer #(
   parameter int SEL_W  = 5,
   parameter int DATA_W = 16,
   parameter int SETTLE = 2
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              continuous,
   input  logic              abort,
   input  logic [SEL_W-1:0]  first_reg,
   input  logic [SEL_W-1:0]  last_reg,
   output logic [SEL_W-1:0]  select,
   input  logic [DATA_W-1:0] register_value,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SEL_W-1:0]  out_index,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_PRESENT = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

   state_t              r_state;
   logic [SEL_W-1:0]    r_select;
   logic [3:0]          r_cnt;
   logic [SEL_W-1:0]    r_first;
   logic [SEL_W-1:0]    r_last;
   logic                r_cont;
   logic                r_out_valid;
   logic [SEL_W-1:0]    r_out_index;
   logic [DATA_W-1:0]   r_out_data;
   logic                r_busy;
   logic                r_done;

   state_t              w_state_next;
   logic [SEL_W-1:0]    w_select_next;
   logic [3:0]          w_cnt_next;
   logic [SEL_W-1:0]    w_first_next;
   logic [SEL_W-1:0]    w_last_next;
   logic                w_cont_next;
   logic                w_out_valid_next;
   logic [SEL_W-1:0]    w_out_index_next;
   logic [DATA_W-1:0]   w_out_data_next;
   logic                w_done_next;
   logic                w_handshake;

   assign w_handshake = r_out_valid & out_ready;

   always_comb begin
      w_state_next     = r_state;
      w_select_next    = r_select;
      w_cnt_next       = r_cnt;
      w_first_next     = r_first;
      w_last_next      = r_last;
      w_cont_next      = r_cont;
      w_out_valid_next = r_out_valid;
      w_out_index_next = r_out_index;
      w_out_data_next  = r_out_data;
      w_done_next      = 1'b0;

      // abort wins over everything; select is left where it was
      if (abort) begin
         w_state_next     = ST_IDLE;
         w_out_valid_next = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  w_first_next  = first_reg;
                  w_last_next   = last_reg;
                  w_cont_next   = continuous;
                  w_select_next = first_reg;
                  w_cnt_next    = CNT_LOAD;
                  w_state_next  = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (r_cnt != 4'd0) begin
                  w_cnt_next = r_cnt - 4'd1;
               end else begin
                  w_out_data_next  = register_value;
                  w_out_index_next = r_select;
                  w_out_valid_next = 1'b1;
                  w_state_next     = ST_PRESENT;
               end
            end
            ST_PRESENT: begin
               if (w_handshake) begin
                  w_out_valid_next = 1'b0;
                  if (r_select != r_last) begin
                     // natural modulo wrap gives the first>last walk for free
                     w_select_next = r_select + 1'b1;
                     w_cnt_next    = CNT_LOAD;
                     w_state_next  = ST_WAIT;
                  end else begin
                     w_done_next = 1'b1;
                     if (r_cont) begin
                        w_select_next = r_first;
                        w_cnt_next    = CNT_LOAD;
                        w_state_next  = ST_WAIT;
                     end else begin
                        w_state_next = ST_IDLE;
                     end
                  end
               end
            end
            default: begin
               w_state_next     = ST_IDLE;
               w_out_valid_next = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= ST_IDLE;
         r_select    <= '0;
         r_cnt       <= '0;
         r_first     <= '0;
         r_last      <= '0;
         r_cont      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_index <= '0;
         r_out_data  <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_select    <= w_select_next;
         r_cnt       <= w_cnt_next;
         r_first     <= w_first_next;
         r_last      <= w_last_next;
         r_cont      <= w_cont_next;
         r_out_valid <= w_out_valid_next;
         r_out_index <= w_out_index_next;
         r_out_data  <= w_out_data_next;
         r_busy      <= (w_state_next != ST_IDLE);
         r_done      <= w_done_next;
      end
   end

   assign select    = r_select;
   assign out_valid = r_out_valid;
   assign out_index = r_out_index;
   assign out_data  = r_out_data;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_regfile_dump_sequencer.sv
// Directed bench for regfile_dump_sequencer: a register-file model drives
// register_value and each scenario task checks the streamed transfers.
module tb_regfile_dump_sequencer;

   logic        clk;
   logic        resetn;
   logic        start;
   logic        continuous;
   logic        abort;
   logic [4:0]  first_reg;
   logic [4:0]  last_reg;
   logic [4:0]  select;
   logic [15:0] register_value;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_index;
   logic [15:0] out_data;
   logic        busy;
   logic        done;

   logic [15:0] regs_model [32];
   int total = 0;
   int bad   = 0;

   regfile_dump_sequencer #(.SEL_W(5), .DATA_W(16), .SETTLE(2)) dut (
      .clk(clk), .resetn(resetn), .start(start), .continuous(continuous),
      .abort(abort), .first_reg(first_reg), .last_reg(last_reg),
      .select(select), .register_value(register_value),
      .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
      .out_data(out_data), .busy(busy), .done(done)
   );

   assign register_value = regs_model[select];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_pass(input logic [4:0] f, input logic [4:0] l, input logic c);
      first_reg  = f;
      last_reg   = l;
      continuous = c;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   // Records the next accepted transfer; ok=0 if none arrives in budget.
   task automatic wait_xfer(output logic [4:0] idx, output logic [15:0] data, output bit ok);
      ok   = 1'b0;
      idx  = '0;
      data = '0;
      for (int n = 0; n < 40 && !ok; n++) begin
         if (out_valid && out_ready) begin
            idx  = out_index;
            data = out_data;
            ok   = 1'b1;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      #3;
      total++;
      if (select !== 5'd0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          out_index !== 5'd0 || out_data !== 16'd0) begin
         bad++;
         $display("FAIL reset_values: sel=%0d vld=%b busy=%b done=%b idx=%0d data=%h required all zero",
                  select, out_valid, busy, done, out_index, out_data);
      end
      #9 resetn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (select !== 5'd0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle cyc%0d: sel=%0d vld=%b busy=%b done=%b required zeros",
                     i, select, out_valid, busy, done);
         end
      end
      $display("reset: idle checks done");
   endtask

   task automatic test_single_pass();
      logic [4:0]  idx;
      logic [15:0] data;
      bit          ok;
      out_ready = 1'b1;
      start_pass(5'd1, 5'd5, 1'b0);
      total++;
      if (select !== 5'd1 || out_valid !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL single_T1: sel=%0d vld=%b busy=%b required sel=1 vld=0 busy=1", select, out_valid, busy);
      end
      tick();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL single_T2: vld=%b required 0", out_valid);
      end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_index !== 5'd1) begin
         bad++;
         $display("FAIL single_T3: vld=%b idx=%0d required vld=1 idx=1", out_valid, out_index);
      end
      for (int i = 0; i < 5; i++) begin
         wait_xfer(idx, data, ok);
         total++;
         if (!ok || idx !== 5'(i + 1) || data !== regs_model[i + 1] || done !== (i == 4)) begin
            bad++;
            $display("FAIL single_xfer%0d: ok=%b idx=%0d data=%h done=%b required idx=%0d data=%h done=%b",
                     i, ok, idx, data, done, i + 1, regs_model[i + 1], (i == 4));
         end
         $display("single: xfer idx=%0d data=%h done=%b", idx, data, done);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL single_busy_end: busy=%b required 0", busy);
      end
      tick();
      total++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL single_after: done=%b vld=%b required 0 0", done, out_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [4:0]  idx;
      logic [15:0] data;
      logic [15:0] held;
      bit          ok;
      int          n;
      out_ready = 1'b1;
      start_pass(5'd1, 5'd5, 1'b0);
      for (int i = 0; i < 2; i++) begin
         wait_xfer(idx, data, ok);
         total++;
         if (!ok || idx !== 5'(i + 1)) begin
            bad++;
            $display("FAIL bp_pre%0d: ok=%b idx=%0d required %0d", i, ok, idx, i + 1);
         end
      end
      out_ready = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      held = regs_model[3];
      total++;
      if (out_valid !== 1'b1 || out_index !== 5'd3 || out_data !== held) begin
         bad++;
         $display("FAIL bp_present: vld=%b idx=%0d data=%h required 1 3 %h", out_valid, out_index, out_data, held);
      end
      regs_model[3] = ~held;
      for (int i = 0; i < 7; i++) begin
         tick();
         total++;
         if (out_valid !== 1'b1 || out_index !== 5'd3 || out_data !== held) begin
            bad++;
            $display("FAIL bp_hold%0d: vld=%b idx=%0d data=%h required 1 3 %h", i, out_valid, out_index, out_data, held);
         end
      end
      regs_model[3] = held;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_xfer(idx, data, ok);
         total++;
         if (!ok || idx !== 5'(i + 3) || data !== regs_model[i + 3]) begin
            bad++;
            $display("FAIL bp_post%0d: ok=%b idx=%0d data=%h required %0d %h", i, ok, idx, data, i + 3, regs_model[i + 3]);
         end
         $display("backpressure: xfer idx=%0d data=%h", idx, data);
      end
      total++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL bp_done: done=%b busy=%b required 1 0", done, busy);
      end
      tick();
   endtask

   task automatic test_wrap_single();
      logic [4:0]  idx;
      logic [15:0] data;
      logic [4:0]  exp_idx [4];
      bit          ok;
      exp_idx[0] = 5'd30; exp_idx[1] = 5'd31; exp_idx[2] = 5'd0; exp_idx[3] = 5'd1;
      out_ready = 1'b1;
      start_pass(5'd30, 5'd1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         wait_xfer(idx, data, ok);
         total++;
         if (!ok || idx !== exp_idx[i] || data !== regs_model[exp_idx[i]] || done !== (i == 3)) begin
            bad++;
            $display("FAIL wrap_xfer%0d: ok=%b idx=%0d data=%h done=%b required %0d %h %b",
                     i, ok, idx, data, done, exp_idx[i], regs_model[exp_idx[i]], (i == 3));
         end
         $display("wrap: xfer idx=%0d data=%h done=%b", idx, data, done);
      end
      tick();
      start_pass(5'd7, 5'd7, 1'b0);
      wait_xfer(idx, data, ok);
      total++;
      if (!ok || idx !== 5'd7 || data !== regs_model[7] || done !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL single_reg: ok=%b idx=%0d data=%h done=%b busy=%b required 7 %h 1 0",
                  ok, idx, data, done, busy, regs_model[7]);
      end
      $display("single_reg: xfer idx=%0d data=%h", idx, data);
      for (int i = 0; i < 6; i++) begin
         tick();
         total++;
         if (out_valid !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL single_reg_extra%0d: vld=%b done=%b required 0 0", i, out_valid, done);
         end
      end
   endtask

   task automatic test_continuous_abort();
      logic [4:0]  idx;
      logic [15:0] data;
      bit          ok;
      out_ready = 1'b1;
      start_pass(5'd2, 5'd3, 1'b1);
      for (int i = 0; i < 4; i++) begin
         wait_xfer(idx, data, ok);
         total++;
         if (!ok || idx !== 5'(2 + (i % 2)) || data !== regs_model[2 + (i % 2)] || done !== (i % 2 == 1)) begin
            bad++;
            $display("FAIL cont_xfer%0d: ok=%b idx=%0d data=%h done=%b required %0d %h %b",
                     i, ok, idx, data, done, 2 + (i % 2), regs_model[2 + (i % 2)], (i % 2 == 1));
         end
         $display("continuous: xfer idx=%0d data=%h done=%b", idx, data, done);
      end
      total++;
      if (busy !== 1'b1 || select !== 5'd2 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL cont_rewind: busy=%b sel=%0d vld=%b required 1 2 0", busy, select, out_valid);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || select !== 5'd2) begin
         bad++;
         $display("FAIL abort_wait: busy=%b vld=%b done=%b sel=%0d required 0 0 0 2", busy, out_valid, done, select);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle%0d: busy=%b vld=%b done=%b required 0 0 0", i, busy, out_valid, done);
         end
      end
   endtask

   task automatic test_start_busy_reset();
      logic [4:0]  idx;
      logic [15:0] data;
      bit          ok;
      int          n;
      out_ready = 1'b1;
      start_pass(5'd10, 5'd13, 1'b0);
      wait_xfer(idx, data, ok);
      total++;
      if (!ok || idx !== 5'd10) begin
         bad++;
         $display("FAIL busy_first: ok=%b idx=%0d required 10", ok, idx);
      end
      out_ready = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      first_reg  = 5'd0;
      last_reg   = 5'd0;
      continuous = 1'b1;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_index !== 5'd11 || select !== 5'd11) begin
         bad++;
         $display("FAIL busy_start_ignored: vld=%b idx=%0d sel=%0d required 1 11 11", out_valid, out_index, select);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_xfer(idx, data, ok);
         total++;
         if (!ok || idx !== 5'(11 + i) || data !== regs_model[11 + i] || done !== (i == 2)) begin
            bad++;
            $display("FAIL busy_xfer%0d: ok=%b idx=%0d data=%h done=%b required %0d %h %b",
                     i, ok, idx, data, done, 11 + i, regs_model[11 + i], (i == 2));
         end
         $display("start_busy: xfer idx=%0d data=%h done=%b", idx, data, done);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL busy_end: busy=%b required 0", busy);
      end
      tick();
      start_pass(5'd20, 5'd25, 1'b0);
      #2 resetn = 1'b0;
      #1;
      total++;
      if (select !== 5'd0 || busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || out_index !== 5'd0) begin
         bad++;
         $display("FAIL async_reset: sel=%0d busy=%b vld=%b done=%b idx=%0d required zeros",
                  select, busy, out_valid, done, out_index);
      end
      #2 resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_release%0d: busy=%b vld=%b done=%b required 0 0 0", i, busy, out_valid, done);
         end
      end
      start_pass(5'd4, 5'd5, 1'b0);
      for (int i = 0; i < 2; i++) begin
         wait_xfer(idx, data, ok);
         total++;
         if (!ok || idx !== 5'(4 + i) || data !== regs_model[4 + i] || done !== (i == 1)) begin
            bad++;
            $display("FAIL restart_xfer%0d: ok=%b idx=%0d data=%h done=%b required %0d %h %b",
                     i, ok, idx, data, done, 4 + i, regs_model[4 + i], (i == 1));
         end
         $display("restart: xfer idx=%0d data=%h done=%b", idx, data, done);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs_model[i] = 16'(i * 16'h0731) ^ 16'hC3A5;
      start      = 1'b0;
      continuous = 1'b0;
      abort      = 1'b0;
      first_reg  = '0;
      last_reg   = '0;
      out_ready  = 1'b0;
      test_reset();
      test_single_pass();
      test_backpressure();
      test_wrap_single();
      test_continuous_abort();
      test_start_busy_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
